// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared ISA constants for the instruction encoder.
// It holds the opcodes, the ALU and CTRL immediate codes (these are shared
// with the decoder), the request-kind enum, the FSM state type and the
// field packing and legality helpers.
// Optional feature macro: INSTR_ENC_NOP_PAD_EN adds the EMIT_PAD state.
package instr_enc_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ARITH2 = 4'h1;
  localparam logic [3:0] OP_ARITH1 = 4'h2;
  localparam logic [3:0] OP_MOVI   = 4'h3;
  localparam logic [3:0] OP_ADDI   = 4'h4;
  localparam logic [3:0] OP_SUBI   = 4'h5;
  localparam logic [3:0] OP_LOAD   = 4'h6;
  localparam logic [3:0] OP_STOR   = 4'h7;
  localparam logic [3:0] OP_BEQ    = 4'h8;
  localparam logic [3:0] OP_BGE    = 4'h9;
  localparam logic [3:0] OP_BLE    = 4'hA;
  localparam logic [3:0] OP_BC     = 4'hB;
  localparam logic [3:0] OP_J      = 4'hC;
  localparam logic [3:0] OP_CTRL   = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  localparam logic [11:0] CTRL_STC   = 12'h001;
  localparam logic [11:0] CTRL_STB   = 12'h002;
  localparam logic [11:0] CTRL_RESET = 12'hAAA;
  localparam logic [11:0] CTRL_HALT  = 12'hFFF;

  typedef enum logic [3:0] {
    K_NOP, K_ARITH2, K_ARITH1, K_MOVI_L, K_MOVI_H, K_ADDI, K_SUBI, K_LOAD,
    K_STOR, K_BEQ, K_BGE, K_BLE, K_BC, K_J, K_LI16, K_CTRL
  } req_kind_e;

  typedef enum logic [1:0] {
    S_IDLE, S_EMIT_HI
`ifdef INSTR_ENC_NOP_PAD_EN
    , S_EMIT_PAD
`endif
  } state_e;

  function automatic logic is_branch(input req_kind_e k);
    return (k == K_BEQ) || (k == K_BGE) || (k == K_BLE) || (k == K_BC) || (k == K_J);
  endfunction

  // Bits above the immediate field must replicate the field MSB.
  function automatic logic req_legal(input req_kind_e k, input logic [2:0] f,
                                     input logic [15:0] imm);
    logic ok;
    ok = 1'b1;
    case (k)
      K_MOVI_L, K_MOVI_H:        ok = (&imm[15:7]) | ~(|imm[15:7]);
      K_ADDI, K_SUBI, K_LOAD, K_STOR,
      K_BEQ, K_BGE, K_BLE:       ok = (&imm[15:5]) | ~(|imm[15:5]);
      K_BC, K_J:                 ok = (&imm[15:11]) | ~(|imm[15:11]);
      K_ARITH1, K_CTRL:          ok = ~f[2];
      default:                   ok = 1'b1;
    endcase
    return ok;
  endfunction

  // LI16 encodes its low half here; the high half comes from the FSM.
  function automatic logic [15:0] encode(input req_kind_e k, input logic [2:0] d,
                                         input logic [2:0] s1, input logic [2:0] s2,
                                         input logic [2:0] f, input logic [15:0] imm);
    logic [15:0] w;
    w = 16'h0000;
    case (k)
      K_NOP:             w = 16'h0000;
      K_ARITH2:          w = {OP_ARITH2, d, s1, s2, f};
      K_ARITH1:          w = {OP_ARITH1, d, s1, 3'b000, f};
      K_MOVI_L, K_LI16:  w = {OP_MOVI, d, 1'b0, imm[7:0]};
      K_MOVI_H:          w = {OP_MOVI, d, 1'b1, imm[7:0]};
      K_ADDI:            w = {OP_ADDI, d, s1, imm[5:0]};
      K_SUBI:            w = {OP_SUBI, d, s1, imm[5:0]};
      K_LOAD:            w = {OP_LOAD, d, s1, imm[5:0]};
      K_STOR:            w = {OP_STOR, d, s1, imm[5:0]};
      K_BEQ:             w = {OP_BEQ, d, s1, imm[5:0]};
      K_BGE:             w = {OP_BGE, d, s1, imm[5:0]};
      K_BLE:             w = {OP_BLE, d, s1, imm[5:0]};
      K_BC:              w = {OP_BC, imm[11:0]};
      K_J:               w = {OP_J, imm[11:0]};
      K_CTRL: begin
        case (f[1:0])
          2'd0:    w = {OP_CTRL, CTRL_STC};
          2'd1:    w = {OP_CTRL, CTRL_STB};
          2'd2:    w = {OP_CTRL, CTRL_RESET};
          default: w = {OP_CTRL, CTRL_HALT};
        endcase
      end
      default:           w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO, DEPTH entries (power of 2, >= 2) of W bits.
// Ports: clk_i, rst_n_i (async low), push_i/wdata_i, pop_i, rdata_o (0 when
// empty), full_o, empty_o. A push when full or a pop when empty is ignored.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs operation requests into 16-bit ISA words and queues
// them in a FIFO with valid/ready on both sides. LI16 expands to MOVI_L then
// MOVI_H. Illegal requests are consumed and flagged on err_po one cycle later.
// Ports: clk_pi, rst_n_pi (async low); req_* request side; instr_valid_po /
//   instr_ready_pi / instruction_po issue side; err_po, halted_po,
//   instr_count_po status.
// Optional: INSTR_ENC_NOP_PAD_EN appends a 16'h0000 delay-slot word after
//   every branch or J word.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic             req_valid_pi,
  output logic             req_ready_po,
  input  logic [3:0]       req_kind_pi,
  input  logic [2:0]       req_dst_pi,
  input  logic [2:0]       req_src1_pi,
  input  logic [2:0]       req_src2_pi,
  input  logic [2:0]       req_func_pi,
  input  logic [15:0]      req_imm_pi,
  output logic             instr_valid_po,
  input  logic             instr_ready_pi,
  output logic [15:0]      instruction_po,
  output logic             err_po,
  output logic             halted_po,
  output logic [CNT_W-1:0] instr_count_po
);
  state_e      state_q, state_d;
  logic [10:0] hi_q, hi_d;     // {dst, imm[15:8]} held for the MOVI_H half
  logic        err_q, err_d;
  logic        halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q;

  req_kind_e   kind;
  logic        accept, legal, push, pop, full, empty;
  logic [15:0] push_data;

  assign kind   = req_kind_e'(req_kind_pi);
  assign legal  = req_legal(kind, req_func_pi, req_imm_pi);
  assign req_ready_po = (state_q == S_IDLE) && !full && !halted_q;
  assign accept = req_valid_pi && req_ready_po;
  assign pop    = instr_valid_po && instr_ready_pi;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    push      = 1'b0;
    push_data = 16'h0000;
    err_d     = accept && !legal;
    halted_d  = halted_q | (accept && legal && kind == K_CTRL && req_func_pi == 3'd3);
    case (state_q)
      S_IDLE: begin
        if (accept && legal) begin
          push      = 1'b1;
          push_data = encode(kind, req_dst_pi, req_src1_pi, req_src2_pi, req_func_pi, req_imm_pi);
          if (kind == K_LI16) begin
            state_d = S_EMIT_HI;
            hi_d    = {req_dst_pi, req_imm_pi[15:8]};
          end
`ifdef INSTR_ENC_NOP_PAD_EN
          if (is_branch(kind)) state_d = S_EMIT_PAD;
`endif
        end
      end
      S_EMIT_HI: begin
        if (!full) begin
          push      = 1'b1;
          push_data = {OP_MOVI, hi_q[10:8], 1'b1, hi_q[7:0]};
          state_d   = S_IDLE;
        end
      end
`ifdef INSTR_ENC_NOP_PAD_EN
      S_EMIT_PAD: begin
        if (!full) begin
          push      = 1'b1;
          push_data = 16'h0000;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  instr_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk_i   (clk_pi),
    .rst_n_i (rst_n_pi),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (instruction_po),
    .full_o  (full),
    .empty_o (empty)
  );

  assign instr_valid_po = !empty;
  assign err_po         = err_q;
  assign halted_po      = halted_q;
  assign instr_count_po = cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_kind = '0;
  logic [2:0]  req_dst = '0, req_src1 = '0, req_src2 = '0, req_func = '0;
  logic [15:0] req_imm = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instruction;
  logic        err;
  logic        halted;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk_pi(clk), .rst_n_pi(rst_n),
    .req_valid_pi(req_valid), .req_ready_po(req_ready),
    .req_kind_pi(req_kind), .req_dst_pi(req_dst), .req_src1_pi(req_src1),
    .req_src2_pi(req_src2), .req_func_pi(req_func), .req_imm_pi(req_imm),
    .instr_valid_po(instr_valid), .instr_ready_pi(instr_ready),
    .instruction_po(instruction), .err_po(err), .halted_po(halted),
    .instr_count_po(instr_count)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [2:0]  d, s1, s2, f;
    logic [15:0] imm;
    logic        err;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Waits (bounded) for ready, presents the request for one cycle.
  // Returns at the negedge after the accepting posedge.
  task automatic send(input logic [3:0] k, input logic [2:0] d, input logic [2:0] s1,
                      input logic [2:0] s2, input logic [2:0] f, input logic [15:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", 32'(n < 50), 32'd1);
    req_valid = 1'b1; req_kind = k; req_dst = d; req_src1 = s1;
    req_src2 = s2; req_func = f; req_imm = imm;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [15:0] word);
    chk({name, "_valid"}, 32'(instr_valid), 32'd1);
    chk({name, "_word"}, 32'(instruction), 32'(word));
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    exp_cnt++;
  endtask

  initial begin
    // kind d s1 s2 f imm err word
    vecs.push_back('{4'd1,  3'd3, 3'd1, 3'd2, 3'd0, 16'h0000, 1'b0, 16'h1650});
    vecs.push_back('{4'd1,  3'd7, 3'd7, 3'd7, 3'd7, 16'h0000, 1'b0, 16'h1FFF});
    vecs.push_back('{4'd2,  3'd2, 3'd5, 3'd6, 3'd3, 16'h0000, 1'b0, 16'h2543});
    vecs.push_back('{4'd2,  3'd2, 3'd5, 3'd6, 3'd4, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{4'd3,  3'd1, 3'd0, 3'd0, 3'd0, 16'h007F, 1'b0, 16'h327F});
    vecs.push_back('{4'd4,  3'd5, 3'd0, 3'd0, 3'd0, 16'hFF80, 1'b0, 16'h3B80});
    vecs.push_back('{4'd3,  3'd1, 3'd0, 3'd0, 3'd0, 16'h0080, 1'b1, 16'h0000});
    vecs.push_back('{4'd5,  3'd1, 3'd1, 3'd0, 3'd0, 16'h0040, 1'b1, 16'h0000});
    vecs.push_back('{4'd5,  3'd1, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b0, 16'h427F});
    vecs.push_back('{4'd6,  3'd2, 3'd3, 3'd0, 3'd0, 16'h001F, 1'b0, 16'h54DF});
    vecs.push_back('{4'd7,  3'd4, 3'd0, 3'd0, 3'd0, 16'hFFE0, 1'b0, 16'h6820});
    vecs.push_back('{4'd8,  3'd0, 3'd6, 3'd0, 3'd0, 16'h0005, 1'b0, 16'h7185});
    vecs.push_back('{4'd9,  3'd1, 3'd2, 3'd0, 3'd0, 16'h0003, 1'b0, 16'h8283});
    vecs.push_back('{4'd10, 3'd7, 3'd0, 3'd0, 3'd0, 16'hFFFE, 1'b0, 16'h9E3E});
    vecs.push_back('{4'd11, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0020, 1'b1, 16'h0000});
    vecs.push_back('{4'd12, 3'd0, 3'd0, 3'd0, 3'd0, 16'h07FF, 1'b0, 16'hB7FF});
    vecs.push_back('{4'd13, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0123, 1'b0, 16'hC123});
    vecs.push_back('{4'd13, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0800, 1'b1, 16'h0000});
    vecs.push_back('{4'd15, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 16'hF001});
    vecs.push_back('{4'd15, 3'd0, 3'd0, 3'd0, 3'd1, 16'h0000, 1'b0, 16'hF002});
    vecs.push_back('{4'd15, 3'd0, 3'd0, 3'd0, 3'd2, 16'h0000, 1'b0, 16'hFAAA});
    vecs.push_back('{4'd15, 3'd0, 3'd0, 3'd0, 3'd4, 16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{4'd0,  3'd5, 3'd5, 3'd5, 3'd5, 16'h1234, 1'b0, 16'h0000});

    // Reset state
    #12;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_word", 32'(instruction), 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Table vectors, one at a time, FIFO drained between
    foreach (vecs[i]) begin
      vec_t v;
      logic br;
      v = vecs[i];
      br = (v.kind >= 4'd9) && (v.kind <= 4'd13) && !v.err;
      send(v.kind, v.d, v.s1, v.s2, v.f, v.imm);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.err));
      if (v.err) begin
        chk($sformatf("v%0d_noenq", i), 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_errpulse", i), 32'(err), 32'd0);
      end else begin
`ifdef INSTR_ENC_NOP_PAD_EN
        if (br) chk($sformatf("v%0d_padready", i), 32'(req_ready), 32'd0);
`endif
        pop_chk($sformatf("v%0d", i), v.word);
`ifdef INSTR_ENC_NOP_PAD_EN
        if (br) pop_chk($sformatf("v%0d_pad", i), 16'h0000);
`endif
        chk($sformatf("v%0d_empty", i), 32'(instr_valid), 32'd0);
        chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'd1);
      end
    end
    chk("count_table", 32'(instr_count), 32'(exp_cnt));

    // LI16 streamed with consumer always ready
    @(negedge clk);
    instr_ready = 1'b1;
    req_valid = 1'b1; req_kind = 4'd14; req_dst = 3'd2; req_imm = 16'hBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("li16_ready_lo", 32'(req_ready), 32'd0);
    chk("li16_lo_word", 32'(instruction), 32'h34EF);
    @(negedge clk);
    chk("li16_ready_back", 32'(req_ready), 32'd1);
    chk("li16_hi_word", 32'(instruction), 32'h35BE);
    @(negedge clk);
    instr_ready = 1'b0;
    exp_cnt += 2;
    chk("li16_empty", 32'(instr_valid), 32'd0);
    chk("li16_count", 32'(instr_count), 32'(exp_cnt));

    // Fill to DEPTH, hold a 5th request, release with one pop
    for (int i = 0; i < 4; i++) send(4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    chk("full_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_kind = 4'd1; req_dst = 3'd3; req_src1 = 3'd1;
    req_src2 = 3'd2; req_func = 3'd0; req_imm = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_hold", 32'(req_ready), 32'd0);
    end
    pop_chk("full_pop0", 16'h0000);
    chk("full_ready_after_pop", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("full_again", 32'(req_ready), 32'd0);
    pop_chk("full_pop1", 16'h0000);
    pop_chk("full_pop2", 16'h0000);
    pop_chk("full_pop3", 16'h0000);
    pop_chk("full_pop4", 16'h1650);
    chk("full_empty", 32'(instr_valid), 32'd0);
    chk("full_count", 32'(instr_count), 32'(exp_cnt));

    // HALT, drain, then async reset clears everything
    send(4'd15, 3'd0, 3'd0, 3'd0, 3'd3, 16'h0);
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_ready", 32'(req_ready), 32'd0);
    pop_chk("halt", 16'hFFFF);
    chk("halt_drained", 32'(instr_valid), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_ready2", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_count", 32'(instr_count), 32'd0);
    chk("hrst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("hrst_ready", 32'(req_ready), 32'd1);

    // Reset while MOVI_H is pending discards it
    for (int i = 0; i < 3; i++) send(4'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    send(4'd14, 3'd2, 3'd0, 3'd0, 3'd0, 16'hBEEF);
    @(negedge clk);
    chk("midli_stall", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midli_ready", 32'(req_ready), 32'd1);
    chk("midli_empty", 32'(instr_valid), 32'd0);
    send(4'd1, 3'd3, 3'd1, 3'd2, 3'd0, 16'h0);
    pop_chk("midli_next", 16'h1650);
    @(negedge clk);
    chk("midli_no_hi", 32'(instr_valid), 32'd0);
    chk("final_count", 32'(instr_count), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
